// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cond_pkg
// Description : Shared encodings for the condition-evaluation stage: the
//               4-bit ARM condition codes and the bit positions of the
//               {N,Z,C,V} flags.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_pkg;

  // ARM condition field encodings (Instr[31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions within the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage : cond_pkg
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_check
// Description : Purely combinational evaluation of an ARM condition field
//               against a set of {N,Z,C,V} flags.
// Ports       : Cond   [3:0] in  - condition field
//               Flags  [3:0] in  - {N,Z,C,V}
//               CondEx       out - 1 when the instruction should execute
// Revision    : 1.0 - initial release
// ============================================================================
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_ge;

  assign w_n  = Flags[FLAG_N];
  assign w_z  = Flags[FLAG_Z];
  assign w_c  = Flags[FLAG_C];
  assign w_v  = Flags[FLAG_V];
  // Signed greater-or-equal: N and V agree
  assign w_ge = (w_n == w_v);

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = w_z;
      COND_NE: CondEx = ~w_z;
      COND_CS: CondEx = w_c;
      COND_CC: CondEx = ~w_c;
      COND_MI: CondEx = w_n;
      COND_PL: CondEx = ~w_n;
      COND_VS: CondEx = w_v;
      COND_VC: CondEx = ~w_v;
      COND_HI: CondEx = w_c & ~w_z;
      COND_LS: CondEx = ~w_c | w_z;
      COND_GE: CondEx = w_ge;
      COND_LT: CondEx = ~w_ge;
      COND_GT: CondEx = ~w_z & w_ge;
      COND_LE: CondEx = w_z | ~w_ge;
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule : cond_check
`default_nettype wire

// File: rtl/cond_logic_mc.sv
`default_nettype none
// ============================================================================
// Module      : cond_logic_mc
// Description : Condition-evaluation and write-gating stage for the
//               multicycle ARM datapath. Holds NZCV, evaluates the condition
//               field, gates PC/register/memory write strobes and keeps
//               saturating executed/squashed writeback counters.
// Ports       : clk        in   - clock, rising edge
//               reset      in   - asynchronous active-low reset
//               Cond  [3:0] in  - condition field
//               ALUFlags[3:0] in - ALU {N,Z,C,V}
//               FlagW [1:0] in  - [1] writes N,Z ; [0] writes C,V
//               PCS, NextPC, RegW, MemW in - decoder/FSM write requests
//               PCWrite, RegWrite, MemWrite out - gated strobes
//               Flags [3:0] out - registered {N,Z,C,V}
//               CondExQ     out - registered condition result
//               ExecCnt, SquashCnt [CNT_W-1:0] out - writeback counters
// Revision    : 1.0 - initial release
// ============================================================================
module cond_logic_mc
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondExQ,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SquashCnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [3:0]       flags_q;
  logic [3:0]       flags_d;
  logic             condex_q;
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] exec_d;
  logic [CNT_W-1:0] squash_q;
  logic [CNT_W-1:0] squash_d;

  logic             w_condex;
  logic [1:0]       w_flag_write;
  logic             w_wb;

  // Condition is evaluated from the registered flags, never from ALUFlags
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (w_condex)
  );

  // Flag writes use the live CondEx so that a conditional flag-setting
  // instruction only updates NZCV when its own condition passes.
  assign w_flag_write = FlagW & {2{w_condex}};
  assign w_wb         = PCS | RegW | MemW;

  always_comb begin
    flags_d = flags_q;
    if (w_flag_write[1]) begin
      flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
    end
    if (w_flag_write[0]) begin
      flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Writeback events are classified by the condition held in CondExQ,
  // the same value that gates the strobes in that cycle.
  always_comb begin
    exec_d   = exec_q;
    squash_d = squash_q;
    if (w_wb && condex_q && (exec_q != c_cnt_max)) begin
      exec_d = exec_q + c_cnt_one;
    end
    if (w_wb && !condex_q && (squash_q != c_cnt_max)) begin
      squash_d = squash_q + c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= w_condex;
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end

  // NextPC is the fetch-state increment and bypasses the condition
  assign PCWrite   = NextPC | (PCS & condex_q);
  assign RegWrite  = RegW & condex_q;
  assign MemWrite  = MemW & condex_q;

  assign Flags     = flags_q;
  assign CondExQ   = condex_q;
  assign ExecCnt   = exec_q;
  assign SquashCnt = squash_q;

endmodule : cond_logic_mc
`default_nettype wire

// File: tb/tb_cond_logic_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_logic_mc
// Description : Directed-vector bench for cond_logic_mc. A 16-bit-counter
//               instance and a 2-bit-counter instance share all stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_logic_mc;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;

  logic        PCWrite, RegWrite, MemWrite, CondExQ;
  logic [3:0]  Flags;
  logic [15:0] ExecCnt, SquashCnt;

  logic        s_PCWrite, s_RegWrite, s_MemWrite, s_CondExQ;
  logic [3:0]  s_Flags;
  logic [1:0]  s_ExecCnt, s_SquashCnt;

  int n_vec  = 0;
  int n_miss = 0;

  cond_logic_mc #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .CondExQ(CondExQ), .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
  );

  cond_logic_mc #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .PCWrite(s_PCWrite), .RegWrite(s_RegWrite), .MemWrite(s_MemWrite),
    .Flags(s_Flags), .CondExQ(s_CondExQ), .ExecCnt(s_ExecCnt),
    .SquashCnt(s_SquashCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check_val("rst_flags",  {28'd0, Flags}, 32'h0);
    check_val("rst_condq",  {31'd0, CondExQ}, 32'h0);
    check_val("rst_exec",   {16'd0, ExecCnt}, 32'h0);
    check_val("rst_squash", {16'd0, SquashCnt}, 32'h0);
    NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1;
    #1;
    check_val("rst_pcw_nextpc", {31'd0, PCWrite}, 32'h1);
    check_val("rst_regw_gated", {31'd0, RegWrite}, 32'h0);
    check_val("rst_memw_gated", {31'd0, MemWrite}, 32'h0);
    NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
    step();
    step();
    #2 reset = 1'b1;

    // ---------------- AL executes ----------------
    Cond = 4'b1110;
    step();
    RegW = 1'b1;
    #1;
    check_val("al_regwrite", {31'd0, RegWrite}, 32'h1);
    step();
    RegW = 1'b0;
    check_val("al_exec", {16'd0, ExecCnt}, 32'h1);
    check_val("al_flags", {28'd0, Flags}, 32'h0);

    // ---------------- EQ / NE ----------------
    FlagW = 2'b11; ALUFlags = 4'b0100;
    step();
    FlagW = 2'b00;
    check_val("z_loaded", {28'd0, Flags}, 32'h4);
    Cond = 4'b0000;
    step();
    RegW = 1'b1;
    #1;
    check_val("eq_regwrite", {31'd0, RegWrite}, 32'h1);
    step();
    RegW = 1'b0;
    check_val("eq_exec", {16'd0, ExecCnt}, 32'h2);
    Cond = 4'b0001;
    step();
    RegW = 1'b1;
    #1;
    check_val("ne_regwrite", {31'd0, RegWrite}, 32'h0);
    step();
    RegW = 1'b0;
    check_val("ne_squash", {16'd0, SquashCnt}, 32'h1);

    // ---------------- independent flag groups ----------------
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0000;
    step();
    FlagW = 2'b10; ALUFlags = 4'b1111;
    step();
    check_val("flagw_nz", {28'd0, Flags}, 32'hC);
    FlagW = 2'b01; ALUFlags = 4'b0011;
    step();
    check_val("flagw_cv", {28'd0, Flags}, 32'hF);

    // ---------------- signed conditions with Flags=1001 ----------------
    FlagW = 2'b11; ALUFlags = 4'b1001;
    step();
    FlagW = 2'b00;
    check_val("flags_1001", {28'd0, Flags}, 32'h9);
    Cond = 4'b1010; step(); check_val("ge_1001", {31'd0, CondExQ}, 32'h1);
    Cond = 4'b1100; step(); check_val("gt_1001", {31'd0, CondExQ}, 32'h1);
    Cond = 4'b1011; step(); check_val("lt_1001", {31'd0, CondExQ}, 32'h0);
    Cond = 4'b1101; step(); check_val("le_1001", {31'd0, CondExQ}, 32'h0);
    Cond = 4'b1000; step(); check_val("hi_1001", {31'd0, CondExQ}, 32'h0);
    Cond = 4'b1001; step(); check_val("ls_1001", {31'd0, CondExQ}, 32'h1);
    Cond = 4'b0110; step(); check_val("vs_1001", {31'd0, CondExQ}, 32'h1);
    Cond = 4'b1111; step(); check_val("nv_1001", {31'd0, CondExQ}, 32'h0);

    // Failed condition blocks a flag write
    Cond = 4'b1011; FlagW = 2'b11; ALUFlags = 4'b0000;
    step();
    check_val("flagw_blocked", {28'd0, Flags}, 32'h9);

    // Same-edge flag write and capture: CondExQ sees pre-update flags
    Cond = 4'b1010; FlagW = 2'b11; ALUFlags = 4'b1000;
    step();
    FlagW = 2'b00;
    check_val("same_edge_condq", {31'd0, CondExQ}, 32'h1);
    check_val("same_edge_flags", {28'd0, Flags}, 32'h8);

    // ---------------- PC gating ----------------
    Cond = 4'b0000;               // Z=0 -> fails
    step();
    NextPC = 1'b1;
    #1;
    check_val("nextpc_bypass", {31'd0, PCWrite}, 32'h1);
    NextPC = 1'b0; PCS = 1'b1; MemW = 1'b1;
    #1;
    check_val("pcs_failed", {31'd0, PCWrite}, 32'h0);
    check_val("memw_failed", {31'd0, MemWrite}, 32'h0);
    step();
    PCS = 1'b0; MemW = 1'b0;
    check_val("pcs_squash", {16'd0, SquashCnt}, 32'h2);
    Cond = 4'b1110;
    step();
    PCS = 1'b1;
    #1;
    check_val("pcs_pass", {31'd0, PCWrite}, 32'h1);
    step();
    PCS = 1'b0;
    check_val("pcs_exec", {16'd0, ExecCnt}, 32'h3);

    // ---------------- saturation ----------------
    check_val("sat_exec_pre", {30'd0, s_ExecCnt}, 32'h3);
    RegW = 1'b1;
    for (int i = 0; i < 5; i++) step();
    RegW = 1'b0;
    check_val("wide_exec_8", {16'd0, ExecCnt}, 32'h8);
    check_val("sat_exec_hold", {30'd0, s_ExecCnt}, 32'h3);
    Cond = 4'b1111;
    step();
    RegW = 1'b1;
    for (int i = 0; i < 2; i++) step();
    RegW = 1'b0;
    check_val("wide_squash_4", {16'd0, SquashCnt}, 32'h4);
    check_val("sat_squash_3", {30'd0, s_SquashCnt}, 32'h3);

    // ---------------- asynchronous reset mid-instruction ----------------
    Cond = 4'b1110;
    step();
    RegW = 1'b1;
    #1;
    check_val("pre_rst_regw", {31'd0, RegWrite}, 32'h1);
    reset = 1'b0;
    #1;
    check_val("arst_regw", {31'd0, RegWrite}, 32'h0);
    check_val("arst_flags", {28'd0, Flags}, 32'h0);
    check_val("arst_exec", {16'd0, ExecCnt}, 32'h0);
    check_val("arst_squash", {16'd0, SquashCnt}, 32'h0);
    check_val("arst_sat_exec", {30'd0, s_ExecCnt}, 32'h0);
    check_val("arst_condq", {31'd0, CondExQ}, 32'h0);
    RegW = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check_val("post_rst_condq", {31'd0, CondExQ}, 32'h0);
    step();
    check_val("reload_condq", {31'd0, CondExQ}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_cond_logic_mc
`default_nettype wire

// File: doc/cond_logic_mc.md
Name: cond_logic_mc

Overview:
- Condition-evaluation and write-gating stage for the multicycle ARM datapath.
- Sits directly downstream of the instruction decoder and consumes its FlagW, PCS, NextPC, RegW and MemW outputs.
- Holds the architectural NZCV flags and evaluates the instruction's 4-bit condition field against them.
- Produces the gated PCWrite, RegWrite and MemWrite strobes for the datapath, plus saturating executed/squashed instruction counters for lab verification.

Parameters:
CNT_W, 16, width of the executed and squashed counters; minimum 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
Cond  input  4  instruction condition field, Instr[31:28].
ALUFlags  input  4  ALU result flags {N,Z,C,V} for the current cycle.
FlagW  input  2  flag-write request from the decoder; [1] selects N,Z and [0] selects C,V.
PCS  input  1  PC-source-is-result request (branch, or write to R15).
NextPC  input  1  unconditional PC update (fetch state).
RegW  input  1  register-write request from the main FSM.
MemW  input  1  memory-write request from the main FSM.
PCWrite  output  1  gated PC write enable.
RegWrite  output  1  gated register-file write enable.
MemWrite  output  1  gated memory write enable.
Flags  output  4  current registered {N,Z,C,V}.
CondExQ  output  1  registered condition result.
ExecCnt  output  CNT_W  count of executed writeback events.
SquashCnt  output  CNT_W  count of squashed writeback events.

Behaviour:
- Reset (reset=0, asynchronous): Flags=4'b0000, CondExQ=0, ExecCnt=0, SquashCnt=0. Gated outputs then follow the rules below (PCWrite=NextPC; RegWrite=MemWrite=0). No clock edge is required.
- CondEx (combinational, from registered Flags):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 is never-execute, 0.
- CondExQ <= CondEx on every rising edge (no enable). The decoder evaluates the condition in the decode state; writeback states one or more cycles later use CondExQ.
  - Because Cond and Flags are stable across an instruction's later states, CondExQ remains valid through writeback.
- Flag write: FlagWrite = FlagW & {2{CondEx}}, using the unregistered CondEx.
  - FlagWrite[1] loads Flags[3:2] from ALUFlags[3:2].
  - FlagWrite[0] loads Flags[1:0] from ALUFlags[1:0].
  - The two groups update independently. A group that is not written holds its value.
- Gating (combinational, zero latency):
  - PCWrite = NextPC | (PCS & CondExQ).
  - RegWrite = RegW & CondExQ.
  - MemWrite = MemW & CondExQ.
  - NextPC always passes through, even when the condition fails.
- Counters: wb = PCS|RegW|MemW.
  - On a clock edge with wb & CondExQ, ExecCnt increments.
  - On a clock edge with wb & ~CondExQ, SquashCnt increments.
  - Both counters saturate at all-ones and never wrap.
  - The FSM guarantees wb for at most one cycle per instruction. Multi-cycle wb assertion is counted per cycle, with no special handling.
- Simultaneous events:
  - Flag write and CondExQ capture on the same edge: CondExQ captures CondEx computed from the pre-update Flags.
  - Gated outputs in a cycle use the CondExQ value held in that cycle.
- Reset mid-instruction clears CondExQ, so any pending RegW/MemW/PCS is squashed until CondExQ is reloaded.

Decomposition:
- Package cond_pkg holds:
  - COND_EQ..COND_NV localparams (4 bits each).
  - Flag index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module cond_check: purely combinational, inputs Cond[3:0] and Flags[3:0], output CondEx. It is instantiated once.
- Registers (flags, CondExQ, counters) stay in the top module.

Test Plan:
- Reset low, then release; Cond=1110, RegW=1 for 1 cycle after 1 clk -> RegWrite=1, ExecCnt=1, Flags=0000.
- Load ALUFlags=0100 with FlagW=11 and Cond=1110; next instruction Cond=0000 (EQ), RegW pulse -> RegWrite=1. Repeat with Cond=0001 (NE) -> RegWrite=0, SquashCnt increments.
- FlagW=10 with ALUFlags=1111 from Flags=0000 -> Flags=1100 (C,V held). FlagW=01 with ALUFlags=0011 -> Flags=1111.
- Flags=1001 (N=1,V=1): Cond=1010 GE -> CondEx=1; Cond=1100 GT -> 1; Cond=1011 LT -> 0. Cond=1111 -> 0 for any flags.
- NextPC=1 with Cond=0000 and Z=0 -> PCWrite=1. PCS=1 with failed condition -> PCWrite=0 and MemW gated to MemWrite=0.
- CNT_W=2: 5 executed writebacks -> ExecCnt saturates at 3. Assert reset mid-stream -> all counters and Flags return to 0 immediately, without a clock edge.
